// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, pairs each memory word with its PC and
// feeds IF/ID with a 1-entry skid. Optional misaligned-redirect fault via FETCH_ALIGN_CHECK_EN.
module fetch_controller #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [31:0]       imem_instruction,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              fault
);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_valid_q, inflight_valid_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              misaligned_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned_s = (redirect_pc[1:0] != 2'b00);
    assign fault        = (state_q == ST_FAULT);
`else
    assign misaligned_s = 1'b0;
    assign fault        = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_STREAM;
            fetch_pc_q       <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            skid_instr_q     <= 32'h0000_0000;
            skid_pc_q        <= RESET_PC;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
        end
    end

    // Next state: redirect beats stall beats advance; FAULT is terminal until reset
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;
        case (state_q)
            ST_STREAM, ST_HOLD: begin
                if (redirect) begin
                    inflight_valid_d = 1'b0;
                    if (misaligned_s) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d    = ST_STREAM;
                        fetch_pc_d = redirect_pc;
                    end
                end else if (stall && (state_q == ST_HOLD)) begin
                    state_d = ST_HOLD;
                end else if (stall && inflight_valid_q) begin
                    // Park the word being presented; memory keeps re-reading fetch_pc meanwhile
                    state_d       = ST_HOLD;
                    skid_instr_d  = imem_instruction;
                    skid_pc_d     = inflight_pc_q;
                    inflight_pc_d = fetch_pc_q;
                end else begin
                    state_d          = ST_STREAM;
                    inflight_pc_d    = fetch_pc_q;
                    inflight_valid_d = 1'b1;
                    fetch_pc_d       = fetch_pc_q + PC_STEP;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d          = ST_STREAM;
                inflight_valid_d = 1'b0;
            end
        endcase
    end

    // Output mux toward IF/ID
    always_comb begin
        if_valid = 1'b0;
        if_instr = 32'h0000_0000;
        if_pc    = inflight_pc_q;
        case (state_q)
            ST_STREAM: begin
                if_valid = inflight_valid_q;
                if_instr = inflight_valid_q ? imem_instruction : 32'h0000_0000;
                if_pc    = inflight_pc_q;
            end
            ST_HOLD: begin
                if_valid = 1'b1;
                if_instr = skid_instr_q;
                if_pc    = skid_pc_q;
            end
            ST_FAULT: begin
                if_valid = 1'b0;
                if_instr = 32'h0000_0000;
                if_pc    = inflight_pc_q;
            end
            default: begin
                if_valid = 1'b0;
                if_instr = 32'h0000_0000;
                if_pc    = inflight_pc_q;
            end
        endcase
    end

    assign imem_address = fetch_pc_q;
    assign if_pc_plus4  = if_pc + PC_STEP;

endmodule
